// File: rtl/run_ctrl.sv
// Execution sequencer: gates pipeline advance (cpu_en), drains after a halt syscall,
// supports pause/single-step, arbitrates DM with the debug port and keeps run statistics.
module run_ctrl #(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stop,
  input  logic             step,
  input  logic             halt_ex,
  input  logic             bj_ex,
  input  logic             stall_id,
  input  logic             debug_dm,
  output logic             cpu_en,
  output logic             squash_young,
  output logic             dm_dbg_sel,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycles,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_PAUSE  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CYC_MAX    = {CNT_W{1'b1}};
  localparam logic [15:0]      EVT_MAX    = 16'hFFFF;

  state_e           state_q;
  logic [3:0]       drain_cnt_q;
  logic             step_prev_q;
  logic             step_q;
  logic [CNT_W-1:0] cycles_q;
  logic [15:0]      stall_cnt_q;
  logic [15:0]      flush_cnt_q;

  logic             adv_s;
  logic             in_dbg_state_s;
  logic             step_d;

  // Advance/decode terms taken straight from the registered state.
  always_comb begin
    adv_s          = (state_q == ST_RUN) | (state_q == ST_DRAIN) |
                     ((state_q == ST_PAUSE) & step_q);
    in_dbg_state_s = (state_q == ST_PAUSE) | (state_q == ST_HALTED);
    step_d         = (state_q == ST_PAUSE) & step & ~step_prev_q;
  end

  // All control outputs are held low while reset is asserted.
  always_comb begin
    cpu_en       = rst & adv_s;
    squash_young = rst & (state_q == ST_DRAIN);
    halted       = rst & (state_q == ST_HALTED);
    dm_dbg_sel   = rst & debug_dm & in_dbg_state_s & ~adv_s;
  end

  assign state     = state_q;
  assign cycles    = cycles_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Sequencer FSM plus step edge detector; a halt is only accepted on an enabled cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= 4'd0;
      step_prev_q <= 1'b0;
      step_q      <= 1'b0;
    end else begin
      step_prev_q <= step;
      step_q      <= step_d;
      case (state_q)
        ST_RUN: begin
          if (halt_ex) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= DRAIN_LOAD;
          end else if (stop) begin
            state_q <= ST_PAUSE;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (step_q & halt_ex) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= DRAIN_LOAD;
          end else if (!stop) begin
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_PAUSE;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q == 4'd0) begin
            state_q <= ST_HALTED;
          end else begin
            drain_cnt_q <= drain_cnt_q - 4'd1;
          end
        end
        ST_HALTED: state_q <= ST_HALTED;
        default:   state_q <= ST_RUN;
      endcase
    end
  end

  // Saturating statistics, advanced only on enabled cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycles_q    <= '0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else if (adv_s) begin
      if (cycles_q != CYC_MAX) begin
        cycles_q <= cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (stall_id && (stall_cnt_q != EVT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (bj_ex && (flush_cnt_q != EVT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

endmodule
